// File: rtl/crc_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// crc_engine : streaming CRC generator/checker, DATA_W/8 bytes per cycle
// Rev 1.0
// ============================================================================
module crc_engine #(
  parameter int          CRC_W   = 32,
  parameter int          DATA_W  = 8,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W/8-1:0]   in_keep,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CRC_W-1:0]      out_crc,
  output logic                  out_match,
  output logic                  busy,
  output logic                  sop_err
);

  localparam int               LANES     = DATA_W / 8;
  localparam logic [CRC_W-1:0] C_POLY    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] C_INIT    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] C_XOR_OUT = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] C_RESIDUE = RESIDUE[CRC_W-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CRC_W-1:0] crc;

  function automatic logic [CRC_W-1:0] reflect_w(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // Register is kept in normal (MSB-first) form; REFLECT only changes bit order within each byte.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d,
                                                input logic [LANES-1:0]  en);
    logic [CRC_W-1:0] r;
    logic [7:0]       b;
    logic             fb;
    r = c;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (en[l]) begin
        b = d[l*8 +: 8];
        for (int k = 0; k < 8; k++) begin
          fb = r[CRC_W-1] ^ (REFLECT ? b[k] : b[7-k]);
          r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? C_POLY : '0);
        end
      end
    end
    return r;
  endfunction

  logic                 accept;
  logic [LANES-1:0]     lane_en;
  logic [CRC_W-1:0]     step_base;
  logic [CRC_W-1:0]     crc_next;
  logic [CRC_W-1:0]     report;

  assign accept    = in_valid && in_ready;
  assign lane_en   = (in_eop && (in_keep != '0)) ? in_keep : '1;
  assign step_base = ((state == IDLE) || in_sop) ? C_INIT : crc;
  assign crc_next  = crc_step(step_base, in_data, lane_en);
  // Residue is expressed in the same bit order as the reported CRC, before XOR_OUT.
  assign report    = REFLECT ? reflect_w(crc_next) : crc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= C_INIT;
      out_valid <= 1'b0;
      out_crc   <= '0;
      out_match <= 1'b0;
      sop_err   <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      sop_err <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if ((state == IDLE) && !in_sop) begin
              sop_err <= 1'b1;
            end else begin
              crc  <= crc_next;
              busy <= 1'b1;
              if (in_eop) begin
                state     <= DONE;
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
                out_crc   <= report ^ C_XOR_OUT;
                out_match <= (report == C_RESIDUE);
              end else begin
                state <= ACCUM;
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_crc_engine : directed self-checking bench for crc_engine (8- and 32-bit beats)
// Rev 1.0
// ============================================================================
module tb_crc_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit beat instance
  logic        v8, rdy8, sop8, eop8, ov8, ordy8, match8, busy8, serr8;
  logic [7:0]  d8;
  logic [0:0]  keep8;
  logic [31:0] crc8;

  crc_engine #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_keep(keep8), .in_sop(sop8), .in_eop(eop8), .out_valid(ov8),
    .out_ready(ordy8), .out_crc(crc8), .out_match(match8), .busy(busy8),
    .sop_err(serr8)
  );

  // 32-bit beat instance
  logic        v32, rdy32, sop32, eop32, ov32, ordy32, match32, busy32, serr32;
  logic [31:0] d32;
  logic [3:0]  keep32;
  logic [31:0] crc32;

  crc_engine #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_keep(keep32), .in_sop(sop32), .in_eop(eop32), .out_valid(ov32),
    .out_ready(ordy32), .out_crc(crc32), .out_match(match32), .busy(busy32),
    .sop_err(serr32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic sop, input logic eop);
    v8 = 1'b1; d8 = d; sop8 = sop; eop8 = eop; keep8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; sop8 = 1'b0; eop8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] keep,
                        input logic sop, input logic eop);
    v32 = 1'b1; d32 = d; keep32 = keep; sop32 = sop; eop32 = eop;
    @(posedge clk); #1;
    v32 = 1'b0; sop32 = 1'b0; eop32 = 1'b0;
  endtask

  // Sends "123456789" as a single frame; eop beat optional so trailing bytes can follow.
  task automatic send_digits(input logic with_eop);
    string s;
    s = "123456789";
    for (int i = 0; i < 9; i++)
      send8(s[i], i == 0, with_eop && (i == 8));
  endtask

  task automatic drain8;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0;
  endtask

  logic [31:0] held_crc;

  initial begin
    rst = 1'b1;
    v8 = 0; d8 = 0; keep8 = 0; sop8 = 0; eop8 = 0; ordy8 = 0;
    v32 = 0; d32 = 0; keep32 = 0; sop32 = 0; eop32 = 0; ordy32 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", ov8, 0);
    check("rst_out_crc", crc8, 0);
    check("rst_out_match", match8, 0);
    check("rst_sop_err", serr8, 0);
    check("rst_busy", busy8, 0);
    check("rst_in_ready", rdy8, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Standard check value, result one cycle after eop
    send_digits(1'b1);
    check("digits_valid", ov8, 1);
    check("digits_crc", crc8, 32'hCBF43926);
    check("digits_match", match8, 0);
    check("digits_in_ready", rdy8, 0);

    // Back-pressure: result held, offered beat not consumed
    held_crc = crc8;
    v8 = 1'b1; d8 = 8'h00; sop8 = 1'b1; eop8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", ov8, 1);
      check("hold_crc", crc8, held_crc);
      check("hold_in_ready", rdy8, 0);
    end
    v8 = 1'b0; sop8 = 1'b0; eop8 = 1'b0;
    drain8();
    check("release_valid", ov8, 0);
    check("release_busy", busy8, 0);
    check("release_in_ready", rdy8, 1);
    @(posedge clk); #1;
    check("no_stray_frame", ov8, 0);

    // Frame followed by its own CRC hits the residue
    send_digits(1'b0);
    send8(8'h26, 0, 0);
    send8(8'h39, 0, 0);
    send8(8'hF4, 0, 0);
    send8(8'hCB, 0, 1);
    check("residue_match", match8, 1);
    check("residue_crc", crc8, 32'h2144DF1C);
    drain8();

    // Single payload bit flipped
    send8(8'h30, 1, 0);
    for (int i = 1; i < 9; i++) send8(8'h31 + i[7:0], 0, 0);
    send8(8'h26, 0, 0);
    send8(8'h39, 0, 0);
    send8(8'hF4, 0, 0);
    send8(8'hCB, 0, 1);
    check("flip_valid", ov8, 1);
    check("flip_match", match8, 0);
    drain8();

    // Beat without sop while idle
    send8(8'hAA, 0, 0);
    check("nosop_pulse", serr8, 1);
    check("nosop_busy", busy8, 0);
    @(posedge clk); #1;
    check("nosop_pulse_end", serr8, 0);

    // sop mid-frame restarts; only the second frame reports
    send8(8'h61, 1, 0);
    send8(8'h62, 0, 0);
    send8(8'h31, 1, 0);
    check("restart_no_valid", ov8, 0);
    for (int i = 1; i < 9; i++) send8(8'h31 + i[7:0], 0, i == 8);
    check("restart_crc", crc8, 32'hCBF43926);
    drain8();

    // Reset on the third byte of a frame
    send8(8'h31, 1, 0);
    send8(8'h32, 0, 0);
    v8 = 1'b1; d8 = 8'h33; rst = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; rst = 1'b0;
    check("midrst_busy", busy8, 0);
    check("midrst_in_ready", rdy8, 1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_valid", ov8, 0);
    send_digits(1'b1);
    check("midrst_clean_crc", crc8, 32'hCBF43926);
    check("midrst_clean_valid", ov8, 1);
    drain8();

    // 32-bit beats with partial final beat
    send32(32'h31323334, 4'b1111, 1, 0);
    send32(32'h35363738, 4'b1111, 0, 0);
    send32(32'h39000000, 4'b1000, 0, 1);
    check("w32_valid", ov32, 1);
    check("w32_crc", crc32, 32'hCBF43926);
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;

    // All-zero keep on eop counts as a full beat: CRC of "12345678"
    send32(32'h31323334, 4'b1111, 1, 0);
    send32(32'h35363738, 4'b0000, 0, 1);
    check("w32_keep0_crc", crc32, 32'h9AE0DAAF);
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 32, CRC register width (8..32).
REQ-002 SHALL have parameter DATA_W, default 8, input beat width (multiple of 8, 8..64).
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7, generator polynomial, normal form, CRC_W bits.
REQ-004 SHALL have parameter INIT, default 32'hFFFFFFFF, register value at frame start.
REQ-005 SHALL have parameter XOR_OUT, default 32'hFFFFFFFF, applied to the reported CRC only.
REQ-006 SHALL have parameter REFLECT, default 1; 1 = bits LSB-first per byte and result reflected, 0 = MSB-first, unreflected.
REQ-007 SHALL have parameter RESIDUE, default 32'hDEBB20E3, raw register value indicating a good frame in check mode.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port in_valid  input  1  input beat valid.
REQ-011 SHALL have port in_ready  output  1  engine accepts beat.
REQ-012 SHALL have port in_data  input  DATA_W  beat; byte lane DATA_W/8-1 (MSBs) processed first.
REQ-013 SHALL have port in_keep  input  DATA_W/8  valid byte lanes, contiguous from MSB lane, honoured on eop beat only.
REQ-014 SHALL have port in_sop / in_eop  input  1 each  first / last beat of frame.
REQ-015 SHALL have port out_valid  output  1  result valid.
REQ-016 SHALL have port out_ready  input  1  result consumed.
REQ-017 SHALL have port out_crc  output  CRC_W  final CRC (reflected if REFLECT, XOR_OUT applied).
REQ-018 SHALL have port out_match  output  1  raw register == RESIDUE at eop.
REQ-019 SHALL have port busy  output  1  state != IDLE.
REQ-020 SHALL have port sop_err  output  1  one-cycle pulse, beat discarded for missing sop.

Function
REQ-021 SHALL implement FSM IDLE, ACCUM, DONE; beat accepted when in_valid && in_ready.
REQ-022 SHALL drive in_ready = 1 in IDLE and ACCUM, 0 in DONE.
REQ-023 IDLE: accepted beat with sop SHALL load crc = step(INIT, beat); eop on same beat -> DONE, else -> ACCUM.
REQ-024 IDLE: accepted beat without sop SHALL be discarded, pulse sop_err next cycle, stay IDLE.
REQ-025 ACCUM: accepted beat SHALL update crc = step(crc, beat); eop -> DONE.
REQ-026 ACCUM: beat with sop SHALL abort current frame without output and restart from INIT with that beat.
REQ-027 step() SHALL process all DATA_W/8 lanes in one cycle, except eop beat processes only lanes set in in_keep; in_keep all-zero on eop treated as all-ones.
REQ-028 DONE: out_valid = 1, out_crc and out_match held stable until out_valid && out_ready, then -> IDLE next cycle.
REQ-029 Latency: out_valid SHALL assert the cycle after the eop beat is accepted.
REQ-030 out_crc SHALL equal (REFLECT ? reverse(crc) : crc) ^ XOR_OUT, truncated to CRC_W; out_match compares raw crc register.
REQ-031 out_crc/out_match SHALL be registered; values outside DONE are don't-care but SHALL not glitch during DONE.

Reset
REQ-032 rst sampled high SHALL force IDLE, crc = INIT, out_valid = 0, out_crc = 0, out_match = 0, sop_err = 0, busy = 0, in_ready = 1 after the edge.
REQ-033 rst mid-frame or in DONE SHALL discard the frame and pending result; no out_valid follows.
REQ-034 rst SHALL take priority over a beat or out_ready presented on the same edge.

Verification (defaults unless stated)
REQ-035 ASCII "123456789" as 9 single-byte frame beats -> out_valid 1 cycle after eop, out_crc = 32'hCBF43926, out_match = 0.
REQ-036 Same 9 bytes followed by 8'h26, 8'h39, 8'hF4, 8'hCB -> out_match = 1; one payload bit flipped -> out_match = 0.
REQ-037 DATA_W=32: beats "1234", "5678", "9" with in_keep = 4'b1000 on eop -> out_crc = 32'hCBF43926.
REQ-038 out_ready held 0 for 5 cycles -> out_valid/out_crc stable, in_ready = 0, no beats consumed; release -> IDLE next cycle.
REQ-039 Beat without sop in IDLE -> sop_err pulse, no state change; sop mid-frame -> restart, only second frame's CRC reported.
REQ-040 rst asserted on 3rd byte of a frame, then clean "123456789" -> single result 32'hCBF43926, no stale out_valid.
